// File: rtl/mux_merge_pkg.sv
// mux_merge_pkg: shared width default, order-tracker states and count-width helper for mux_merge
package mux_merge_pkg;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {SEL_L0, SEL_L1} sel_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/mux_merge_lane_fifo.sv
// lane_fifo: per-lane FIFO; ports clk, reset, push/din in, pop in, head/full/empty out, drop pulse when a push is refused
module lane_fifo
    import mux_merge_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              drop
);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              do_pop, accept;

    assign full   = count == CW'(FIFO_DEPTH);
    assign empty  = count == '0;
    assign do_pop = pop && !empty;
    // a full FIFO still takes a byte when its head leaves in the same cycle
    assign accept = push && (!full || do_pop);
    assign drop   = push && !accept;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) mem[wr_ptr] <= din;
            wr_ptr <= accept ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + CW'(accept) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mux_merge.sv
// mux_merge: re-interleaves two demuxed byte lanes into one registered stream; ports clk, reset, data_in0/valid_in0, data_in1/valid_in1 in, data_out/valid_out/full0/full1 out, overflow out only with MUX_MERGE_OVF_EN
module mux_merge
    import mux_merge_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full0,
`ifdef MUX_MERGE_OVF_EN
    output logic              full1,
    output logic              overflow
`else
    output logic              full1
`endif
);
    logic [DATA_W-1:0] head0, head1;
    logic              empty0, empty1, pop0, pop1, drop0, drop1;
    sel_t              state, state_nxt;

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_lane0 (
        .clk(clk), .reset(reset), .push(valid_in0), .din(data_in0), .pop(pop0),
        .head(head0), .full(full0), .empty(empty0), .drop(drop0)
    );

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_lane1 (
        .clk(clk), .reset(reset), .push(valid_in1), .din(data_in1), .pop(pop1),
        .head(head1), .full(full1), .empty(empty1), .drop(drop1)
    );

    // only the expected lane may pop; an empty expected lane stalls the stream
    always_comb begin
        pop0      = state == SEL_L0 && !empty0;
        pop1      = state == SEL_L1 && !empty1;
        state_nxt = pop0 ? SEL_L1 : pop1 ? SEL_L0 : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEL_L0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= pop0 || pop1;
            data_out  <= pop0 ? head0 : pop1 ? head1 : data_out;
        end
    end

`ifdef MUX_MERGE_OVF_EN
    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else if (drop0 || drop1) overflow <= 1'b1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop0 | drop1;
`endif
endmodule

// File: tb/tb_mux_merge.sv
// tb_mux_merge: scoreboard bench for mux_merge; expected bytes queued at stimulus time, popped by an output monitor
module tb_mux_merge;
    logic       clk, reset;
    logic [7:0] data_in0, data_in1, data_out;
    logic       valid_in0, valid_in1, valid_out, full0, full1;
`ifdef MUX_MERGE_OVF_EN
    logic       overflow;
`endif

    int         checks = 0;
    int         errors = 0;
    int         outcnt = 0;
    logic [7:0] q[$];

    mux_merge #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .data_in0(data_in0), .valid_in0(valid_in0),
        .data_in1(data_in1), .valid_in1(valid_in1),
        .data_out(data_out), .valid_out(valid_out),
        .full0(full0),
`ifdef MUX_MERGE_OVF_EN
        .full1(full1),
        .overflow(overflow)
`else
        .full1(full1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            checks++;
            outcnt++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got %h want nothing", data_out);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL out_data got %h want %h", data_out, e);
                end
            end
        end
    end

    task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        valid_in0 = v0; data_in0 = d0;
        valid_in1 = v1; data_in1 = d1;
        @(posedge clk); #1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input logic junk);
        reset = 1'b1;
        valid_in0 = junk; data_in0 = 8'h77;
        valid_in1 = junk; data_in1 = 8'h78;
        @(posedge clk); #1;
        reset = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        q.delete();
        outcnt = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0) break;
        end
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name, q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid_in0 = 1'b0; valid_in1 = 1'b0; data_in0 = 8'h00; data_in1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++;
        if ({full0, full1} !== 2'b00) begin errors++; $display("FAIL reset_full got %b want 00", {full0, full1}); end
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
`endif
    endtask

    task automatic test_demux;
        logic [7:0] b;
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            b = 8'h10 + 8'(i);
            q.push_back(b);
            if (i % 2 == 0) cyc(1'b1, b, 1'b0, 8'h00);
            else cyc(1'b0, 8'h00, 1'b1, b);
            checks++;
            if (valid_out !== (i != 0)) begin
                errors++;
                $display("FAIL demux_valid[%0d] got %b want %b", i, valid_out, i != 0);
            end
            if (i == 1) begin
                checks++;
                if (data_out !== 8'h10) begin errors++; $display("FAIL demux_first got %h want 10", data_out); end
            end
        end
        idle(1);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h15) begin
            errors++;
            $display("FAIL demux_last got %b/%h want 1/15", valid_out, data_out);
        end
        idle(1);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL demux_end got %b want 0", valid_out); end
        drain("demux");
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'hB0);
        cyc(1'b0, 8'h00, 1'b1, 8'hB1);
        idle(1);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL stall_l1only got %b want 0", valid_out); end
        q.push_back(8'hA0);
        q.push_back(8'hB0);
        cyc(1'b1, 8'hA0, 1'b0, 8'h00);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL stall_bypass got %b want 0", valid_out); end
        idle(1);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'hA0) begin
            errors++;
            $display("FAIL stall_a0 got %b/%h want 1/a0", valid_out, data_out);
        end
        idle(1);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'hB0) begin
            errors++;
            $display("FAIL stall_b0 got %b/%h want 1/b0", valid_out, data_out);
        end
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checks++;
            if (valid_out !== 1'b0 || data_out !== 8'hB0) begin
                errors++;
                $display("FAIL stall_wait[%0d] got %b/%h want 0/b0", i, valid_out, data_out);
            end
        end
        drain("stall");
    endtask

    task automatic test_overflow;
        logic [7:0] exp_l[8];
        do_reset(1'b0);
        q.push_back(8'hEE);
        cyc(1'b1, 8'hEE, 1'b0, 8'h00);
        idle(1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 8'h00);
            checks++;
            if (full0 !== (i >= 4)) begin
                errors++;
                $display("FAIL ovf_full0[%0d] got %b want %b", i, full0, i >= 4);
            end
`ifdef MUX_MERGE_OVF_EN
            checks++;
            if (overflow !== (i == 5)) begin
                errors++;
                $display("FAIL ovf_flag[%0d] got %b want %b", i, overflow, i == 5);
            end
`endif
        end
        exp_l = '{8'hF0, 8'h01, 8'hF1, 8'h02, 8'hF2, 8'h03, 8'hF3, 8'h04};
        for (int i = 0; i < 8; i++) q.push_back(exp_l[i]);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 8'hF0 + 8'(i));
        drain("ovf");
        idle(3);
        checks++;
        if (full0 !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after got full0=%b valid=%b want 0/0", full0, valid_out);
        end
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
`endif
    endtask

    task automatic test_full_pushpop;
        logic [7:0] exp_l[11];
        do_reset(1'b0);
        exp_l = '{8'hEE, 8'hF0, 8'h51, 8'hF1, 8'h52, 8'hF2, 8'h53, 8'hF3, 8'h54, 8'hF4, 8'h55};
        for (int i = 0; i < 11; i++) q.push_back(exp_l[i]);
        cyc(1'b1, 8'hEE, 1'b0, 8'h00);
        idle(1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 8'hF0);
        idle(1);
        checks++;
        if (full0 !== 1'b1) begin errors++; $display("FAIL pp_prefull got %b want 1", full0); end
        cyc(1'b1, 8'h55, 1'b0, 8'h00);
        checks++;
        if (full0 !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h51) begin
            errors++;
            $display("FAIL pp_same got full0=%b out=%b/%h want 1 1/51", full0, valid_out, data_out);
        end
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b want 0", overflow); end
`endif
        for (int i = 1; i <= 4; i++) cyc(1'b0, 8'h00, 1'b1, 8'hF0 + 8'(i));
        drain("pp");
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf_end got %b want 0", overflow); end
`endif
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0);
        q.push_back(8'h99);
        cyc(1'b1, 8'h99, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00);
        drain("mid_pre");
        do_reset(1'b1);
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_out got %b/%h want 0/00", valid_out, data_out);
        end
        checks++;
        if ({full0, full1} !== 2'b00) begin errors++; $display("FAIL mid_full got %b want 00", {full0, full1}); end
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", overflow); end
`endif
        idle(3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_flushed got %b want 0", valid_out); end
        q.push_back(8'h20);
        q.push_back(8'h21);
        cyc(1'b1, 8'h20, 1'b1, 8'h21);
        drain("mid_post");
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            b = 8'h30 + 8'(i);
            q.push_back(b);
            if (i % 2 == 0) cyc(1'b1, b, 1'b0, 8'h00);
            else cyc(1'b0, 8'h00, 1'b1, b);
            if (i % 3 == 2) idle(1);
        end
        drain("wrap");
        idle(2);
        checks++;
        if (outcnt != 20) begin errors++; $display("FAIL wrap_count got %0d want 20", outcnt); end
`ifdef MUX_MERGE_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", overflow); end
`endif
    endtask

    initial begin
        test_reset;
        test_demux;
        test_stall;
        test_overflow;
        test_full_pushpop;
        test_reset_mid;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
